// File: rtl/clint_timer_if.sv
// Register-access handshake between a bus master and the clint_timer block.
// The master drives a read/write request; the slave answers with a one-cycle ready pulse.
interface clint_timer_if;
  logic        i_ren;
  logic        i_wen;
  logic [63:0] i_addr;
  logic [63:0] i_wdata;
  logic [63:0] o_rdata;
  logic        o_ready;

  modport master (output i_ren, i_wen, i_addr, i_wdata, input  o_rdata, o_ready);
  modport slave  (input  i_ren, i_wen, i_addr, i_wdata, output o_rdata, o_ready);
endinterface

// File: rtl/clint_timer.sv
// Machine-mode timer / software-interrupt source feeding the exception unit.
// Optional msip register and software interrupt are enabled by defining CLINT_MSIP_EN.
module clint_timer #(
  parameter logic [63:0] MTIME_ADDR    = 64'h0000_0000_0200_BFF8,
  parameter logic [63:0] MTIMECMP_ADDR = 64'h0000_0000_0200_4000,
  parameter logic [63:0] MSIP_ADDR     = 64'h0000_0000_0200_0000,
  parameter int unsigned PRESCALE      = 1
) (
  input  logic         clk,
  input  logic         rst,
  clint_timer_if.slave bus,
  input  logic         i_commit,
  input  logic         i_mstatus_mie,
  input  logic         i_mie_mtie,
  input  logic         i_mie_msie,
  output logic         o_trap_ena,
  output logic [63:0]  o_trap_cause,
  input  logic         i_trap_done,
  output logic         o_mtip
);
  localparam logic [63:0] CAUSE_TIMER = 64'h8000_0000_0000_0007;
  localparam logic [15:0] PS_LAST     = 16'(PRESCALE - 1);

  typedef enum logic [1:0] {IDLE, FIRE, WAIT_DONE} state_e;

  state_e      state_q;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [63:0] rdata_q, rdata_d;
  logic [63:0] trap_cause_q;
  logic [63:0] rd_val;
  logic [63:0] cause_sel;
  logic [15:0] ps_cnt_q, ps_cnt_d;
  logic        ready_q;
  logic        trap_ena_q;
  logic        req;
  logic        tick;
  logic        hit_mtime;
  logic        hit_mtimecmp;
  logic        pend;

  assign req          = bus.i_ren | bus.i_wen;
  assign hit_mtime    = (bus.i_addr == MTIME_ADDR);
  assign hit_mtimecmp = (bus.i_addr == MTIMECMP_ADDR);
  assign tick         = (ps_cnt_q == PS_LAST);
  assign o_mtip       = (mtime_q >= mtimecmp_q);

`ifdef CLINT_MSIP_EN
  localparam logic [63:0] CAUSE_SW = 64'h8000_0000_0000_0003;

  logic msip_q;
  logic msip_d;
  logic hit_msip;
  logic sw_pend;

  assign hit_msip = (bus.i_addr == MSIP_ADDR);
  assign msip_d   = (bus.i_wen && hit_msip) ? bus.i_wdata[0] : msip_q;
  assign sw_pend  = msip_q & i_mie_msie;
  // Software interrupt wins when both sources are pending at the decision point.
  assign pend      = sw_pend | (o_mtip & i_mie_mtie);
  assign cause_sel = sw_pend ? CAUSE_SW : CAUSE_TIMER;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      msip_q <= 1'b0;
    end else begin
      msip_q <= msip_d;
    end
  end
`else
  logic unused_msip;
  assign unused_msip = i_mie_msie ^ (bus.i_addr == MSIP_ADDR);
  assign pend        = o_mtip & i_mie_mtie;
  assign cause_sel   = CAUSE_TIMER;
`endif

  always_comb begin
    rd_val = 64'd0;
    if (hit_mtime) begin
      rd_val = mtime_q;
    end else if (hit_mtimecmp) begin
      rd_val = mtimecmp_q;
`ifdef CLINT_MSIP_EN
    end else if (hit_msip) begin
      rd_val = {63'd0, msip_q};
`endif
    end
  end

  // A software write to mtime overrides a coincident tick and restarts the prescaler.
  always_comb begin
    mtime_d    = mtime_q;
    ps_cnt_d   = ps_cnt_q + 16'd1;
    mtimecmp_d = mtimecmp_q;
    if (bus.i_wen && hit_mtime) begin
      mtime_d  = bus.i_wdata;
      ps_cnt_d = 16'd0;
    end else if (tick) begin
      mtime_d  = mtime_q + 64'd1;
      ps_cnt_d = 16'd0;
    end
    if (bus.i_wen && hit_mtimecmp) begin
      mtimecmp_d = bus.i_wdata;
    end
    rdata_d = bus.i_ren ? rd_val : 64'd0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtime_q    <= 64'd0;
      ps_cnt_q   <= 16'd0;
      mtimecmp_q <= '1;
      rdata_q    <= 64'd0;
      ready_q    <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      ps_cnt_q   <= ps_cnt_d;
      mtimecmp_q <= mtimecmp_d;
      rdata_q    <= rdata_d;
      ready_q    <= req;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      trap_ena_q   <= 1'b0;
      trap_cause_q <= 64'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_commit && i_mstatus_mie && pend) begin
            state_q      <= FIRE;
            trap_ena_q   <= 1'b1;
            trap_cause_q <= cause_sel;
          end
        end
        FIRE: begin
          state_q    <= WAIT_DONE;
          trap_ena_q <= 1'b0;
        end
        WAIT_DONE: begin
          if (i_trap_done) begin
            state_q      <= IDLE;
            trap_cause_q <= 64'd0;
          end
        end
        default: begin
          state_q    <= IDLE;
          trap_ena_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_rdata  = rdata_q;
  assign bus.o_ready  = ready_q;
  assign o_trap_ena   = trap_ena_q;
  assign o_trap_cause = trap_cause_q;
endmodule

// File: tb/tb_clint_timer.sv
// Randomised self-checking bench for clint_timer: two instances (PRESCALE 1 and 4)
// compared against a cycle-count based reference model of mtime and the trap handshake.
`timescale 1ns/1ps
module tb_clint_timer;
  localparam logic [63:0] A_MTIME   = 64'h0000_0000_0200_BFF8;
  localparam logic [63:0] A_CMP     = 64'h0000_0000_0200_4000;
  localparam logic [63:0] A_MSIP    = 64'h0000_0000_0200_0000;
  localparam logic [63:0] ONES      = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] CAUSE_TMR = 64'h8000_0000_0000_0007;
  localparam logic [63:0] CAUSE_SW  = 64'h8000_0000_0000_0003;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        commit = 1'b0, mie = 1'b0, mtie = 1'b0, msie = 1'b0, done = 1'b0;
  logic        ena1, mtip1, mtip4, unused_ena4;
  logic [63:0] cause1, unused_cause4;

  clint_timer_if bus1 ();
  clint_timer_if bus4 ();

  clint_timer #(.PRESCALE(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .i_commit(commit), .i_mstatus_mie(mie), .i_mie_mtie(mtie), .i_mie_msie(msie),
    .o_trap_ena(ena1), .o_trap_cause(cause1), .i_trap_done(done), .o_mtip(mtip1)
  );

  clint_timer #(.PRESCALE(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4),
    .i_commit(commit), .i_mstatus_mie(mie), .i_mie_mtie(mtie), .i_mie_msie(msie),
    .o_trap_ena(unused_ena4), .o_trap_cause(unused_cause4), .i_trap_done(done), .o_mtip(mtip4)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [63:0] m_base [2];
  int          m_wcyc [2];
  logic [63:0] m_cmp  [2];
  logic        m_msip [2];
  logic        t_ena, t_busy;
  logic [63:0] t_cause;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // mtime = last written value + elapsed edges / PRESCALE
  function automatic logic [63:0] exp_mtime(input int d);
    int per;
    per = (d == 0) ? 1 : 4;
    return m_base[d] + 64'((cyc - m_wcyc[d]) / per);
  endfunction

  function automatic logic [63:0] model_read(input int d, input logic [63:0] a);
    if (a == A_MTIME) return exp_mtime(d);
    if (a == A_CMP) return m_cmp[d];
`ifdef CLINT_MSIP_EN
    if (a == A_MSIP) return {63'd0, m_msip[d]};
`endif
    return 64'd0;
  endfunction

  task automatic model_write(input int d, input logic [63:0] a, input logic [63:0] wd);
    if (a == A_MTIME) begin
      m_base[d] = wd;
      m_wcyc[d] = cyc;
    end else if (a == A_CMP) begin
      m_cmp[d] = wd;
`ifdef CLINT_MSIP_EN
    end else if (a == A_MSIP) begin
      m_msip[d] = wd[0];
`endif
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_base[d] = 64'd0;
      m_wcyc[d] = cyc;
      m_cmp[d]  = ONES;
      m_msip[d] = 1'b0;
    end
    t_ena   = 1'b0;
    t_busy  = 1'b0;
    t_cause = 64'd0;
  endtask

  // Advance one clock; the trap model sees the pre-edge inputs and register state.
  task automatic tick();
    logic        tp, sp;
    logic [63:0] cz;
    tp = (exp_mtime(0) >= m_cmp[0]) && mtie;
    sp = 1'b0;
`ifdef CLINT_MSIP_EN
    sp = m_msip[0] && msie;
`endif
    cz = sp ? CAUSE_SW : CAUSE_TMR;
    @(posedge clk);
    cyc++;
    if (!rst) begin
      model_reset();
    end else if (t_ena) begin
      t_ena = 1'b0;
    end else if (t_busy) begin
      if (done) begin
        t_busy  = 1'b0;
        t_cause = 64'd0;
      end
    end else if (commit && mie && (tp || sp)) begin
      t_ena   = 1'b1;
      t_busy  = 1'b1;
      t_cause = cz;
    end
    @(negedge clk);
  endtask

  task automatic drive(input int d, input logic r, input logic w, input logic [63:0] a, input logic [63:0] wd);
    if (d == 0) begin
      bus1.i_ren = r; bus1.i_wen = w; bus1.i_addr = a; bus1.i_wdata = wd;
    end else begin
      bus4.i_ren = r; bus4.i_wen = w; bus4.i_addr = a; bus4.i_wdata = wd;
    end
  endtask

  function automatic logic [63:0] get_rdata(input int d);
    return (d == 0) ? bus1.o_rdata : bus4.o_rdata;
  endfunction

  function automatic logic get_ready(input int d);
    return (d == 0) ? bus1.o_ready : bus4.o_ready;
  endfunction

  task automatic access(input int d, input logic r, input logic w, input logic [63:0] a,
                        input logic [63:0] wd, input string tag);
    logic [63:0] exp_rd;
    exp_rd = r ? model_read(d, a) : 64'd0;
    drive(d, r, w, a, wd);
    tick();
    drive(d, 1'b0, 1'b0, 64'd0, 64'd0);
    if (w) model_write(d, a, wd);
    check({tag, "_rdy"}, 64'(get_ready(d)), 64'd1);
    check({tag, "_rd"}, get_rdata(d), exp_rd);
    $display("txn %s dut%0d ren=%0b wen=%0b addr=%h wdata=%h rdata=%h", tag, d, r, w, a, wd, get_rdata(d));
  endtask

  task automatic chk_trap(input string tag);
    check({tag, "_mtip"}, 64'(mtip1), 64'(exp_mtime(0) >= m_cmp[0]));
    check({tag, "_mtip4"}, 64'(mtip4), 64'(exp_mtime(1) >= m_cmp[1]));
    check({tag, "_ena"}, 64'(ena1), 64'(t_ena));
    check({tag, "_cause"}, cause1, t_cause);
  endtask

  int          d, g, sel, first, pulses;
  logic        r, w, saw;
  logic [63:0] a, wd;

  initial begin
    drive(0, 1'b0, 1'b0, 64'd0, 64'd0);
    drive(1, 1'b0, 1'b0, 64'd0, 64'd0);
    model_reset();

    // Reset state and readback
    repeat (3) tick();
    check("rst_ready", 64'(bus1.o_ready), 64'd0);
    check("rst_rdata", bus1.o_rdata, 64'd0);
    chk_trap("rst");
    rst = 1'b1;
    access(0, 1'b1, 1'b0, A_CMP, 64'd0, "rd_cmp_rst");
    tick();
    check("rdy_fall", 64'(bus1.o_ready), 64'd0);
    check("rdata_fall", bus1.o_rdata, 64'd0);
    chk_trap("idle");

    // Free-running mtime on both instances with random gaps
    for (int i = 0; i < 8; i++) begin
      d = $urandom_range(0, 1);
      g = $urandom_range(0, 5);
      repeat (g) tick();
      access(d, 1'b1, 1'b0, A_MTIME, 64'd0, "rd_mtime");
    end

    // Gating: pending but missing MIE or commit gives no pulse
    mtie = 1'b1;
    access(0, 1'b0, 1'b1, A_MTIME, 64'd100, "wr_mtime_g");
    access(0, 1'b0, 1'b1, A_CMP, 64'd50, "wr_cmp_g");
    commit = 1'b1; mie = 1'b0;
    repeat (4) begin tick(); chk_trap("gate_nomie"); end
    commit = 1'b0; mie = 1'b1; done = 1'b1;
    repeat (4) begin tick(); chk_trap("gate_nocommit"); end
    done = 1'b0; commit = 1'b0; mie = 1'b0;
    tick();
    commit = 1'b1; mie = 1'b1;
    repeat (3) begin tick(); chk_trap("gate_both"); end
    commit = 1'b0;
    tick();
    done = 1'b1; tick(); done = 1'b0;
    tick(); chk_trap("gate_done");

    // Timer trap with PRESCALE=1, commit held
    access(0, 1'b0, 1'b1, A_MTIME, 64'd0, "wr_mtime_t");
    access(0, 1'b0, 1'b1, A_CMP, 64'd10, "wr_cmp_t");
    commit = 1'b1; mie = 1'b1; mtie = 1'b1;
    first = -1; pulses = 0;
    for (int i = 0; i < 40; i++) begin
      done = (first >= 0 && i == first + 4);
      tick();
      chk_trap("trap");
      if (ena1) begin
        if (first < 0) begin
          first = i;
          check("trap_cause", cause1, CAUSE_TMR);
        end
        pulses++;
      end
    end
    done = 1'b0; commit = 1'b0;
    check("trap_pulses", 64'(pulses), 64'd2);

    // Wrap and prescale on the PRESCALE=4 instance
    access(1, 1'b0, 1'b1, A_MTIME, 64'hFFFF_FFFF_FFFF_FFFE, "wr_wrap");
    repeat (8) tick();
    access(1, 1'b1, 1'b0, A_MTIME, 64'd0, "rd_wrap");
    access(1, 1'b0, 1'b1, A_MTIME, 64'd100, "wr_pre");
    repeat (3) tick();
    access(1, 1'b0, 1'b1, A_MTIME, 64'd500, "wr_race");
    repeat (5) tick();
    access(1, 1'b1, 1'b0, A_MTIME, 64'd0, "rd_race");
    chk_trap("pre");

    // Access corners
    access(0, 1'b1, 1'b1, A_CMP, 64'd5, "rdwr_cmp");
    access(0, 1'b1, 1'b0, A_CMP, 64'd0, "rd_cmp5");
    access(0, 1'b1, 1'b0, 64'h1234, 64'd0, "rd_unmapped");
    access(0, 1'b0, 1'b1, 64'h1234, 64'hDEAD, "wr_unmapped");
    access(0, 1'b1, 1'b0, A_CMP, 64'd0, "rd_cmp_after");
    access(0, 1'b1, 1'b0, A_MSIP, 64'd0, "rd_msip");
    for (int i = 0; i < 12; i++) begin
      d   = $urandom_range(0, 1);
      sel = $urandom_range(0, 3);
      a   = (sel == 0) ? A_MTIME : (sel == 1) ? A_CMP : (sel == 2) ? A_MSIP : {32'd0, $urandom()};
      r   = 1'($urandom_range(0, 1));
      w   = 1'($urandom_range(0, 1));
      if (!r && !w) r = 1'b1;
      wd  = {$urandom(), $urandom()};
      access(d, r, w, a, wd, "rand");
    end
    chk_trap("rand_end");

    // Leave WAIT_DONE, then fire with everything pending
    done = 1'b1; tick(); done = 1'b0; tick();
    access(0, 1'b0, 1'b1, A_CMP, 64'd0, "wr_cmp0");
`ifdef CLINT_MSIP_EN
    msie = 1'b1;
    access(0, 1'b0, 1'b1, A_MSIP, 64'hFF, "wr_msip");
    access(0, 1'b1, 1'b0, A_MSIP, 64'd0, "rd_msip1");
`endif
    commit = 1'b1; mie = 1'b1; mtie = 1'b1;
    saw = 1'b0;
    repeat (3) begin
      tick();
      chk_trap("prio");
      if (ena1) begin
        saw = 1'b1;
`ifdef CLINT_MSIP_EN
        check("prio_cause", cause1, CAUSE_SW);
`else
        check("prio_cause", cause1, CAUSE_TMR);
`endif
      end
    end
    check("prio_fired", 64'(saw), 64'd1);

    // Asynchronous reset in WAIT_DONE with a request in flight
    drive(0, 1'b1, 1'b0, A_MTIME, 64'd0);
    #2 rst = 1'b0;
    #1;
    check("arst_ena", 64'(ena1), 64'd0);
    check("arst_cause", cause1, 64'd0);
    check("arst_mtip", 64'(mtip1), 64'd0);
    check("arst_ready", 64'(bus1.o_ready), 64'd0);
    tick();
    drive(0, 1'b0, 1'b0, 64'd0, 64'd0);
    check("arst_drop", 64'(bus1.o_ready), 64'd0);
    tick();
    rst = 1'b1;
    repeat (5) begin tick(); chk_trap("post_rst"); end
    access(0, 1'b1, 1'b0, A_CMP, 64'd0, "rd_cmp_post");
    commit = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
